// File: rtl/gpio_output_ctrl.sv
// gpio_output_ctrl
//   GPIO output stage between the GPIO register file and the pad ring.
//   Holds a WIDTH-bit output data register (write/set/clear/toggle), adds
//   per-pin open-drain mode and a per-pin timed one-shot inversion pulse,
//   and drives registered pad value and pad output-enable.
//
// Ports:
//   clk_i                 system clock
//   rst_ni                asynchronous active-low reset
//   wr_en_i               single-cycle strobe applying wr_op_i / wr_data_i
//   wr_op_i               00 write, 01 set, 10 clear, 11 toggle
//   wr_data_i             value (write) or pin mask (set/clear/toggle)
//   gpio_direction_i      1 = pin is output
//   gpio_od_i             1 = open-drain, 0 = push-pull
//   pulse_start_i         per-pin pulse request, level-sampled
//   pulse_len_i           pulse length in cycles, shared by all pins
//   gpio_output_o         registered pad output value
//   gpio_output_enable_o  registered pad output enable
//   pulse_busy_o          1 while the pin's pulse counter is non-zero
module gpio_output_ctrl #(
    parameter int unsigned          WIDTH   = 32,
    parameter int unsigned          CNT_W   = 16,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_op_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [WIDTH-1:0] gpio_direction_i,
    input  logic [WIDTH-1:0] gpio_od_i,
    input  logic [WIDTH-1:0] pulse_start_i,
    input  logic [CNT_W-1:0] pulse_len_i,
    output logic [WIDTH-1:0] gpio_output_o,
    output logic [WIDTH-1:0] gpio_output_enable_o,
    output logic [WIDTH-1:0] pulse_busy_o
);

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } wr_op_e;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] busy_d;
    logic [WIDTH-1:0] eff_d;
    logic [WIDTH-1:0] pad_out_d;
    logic [WIDTH-1:0] pad_oe_d;

    // Output data register next state
    always_comb begin
        out_d = out_q;
        if (wr_en_i) begin
            unique case (wr_op_e'(wr_op_i))
                OP_WRITE:  out_d = wr_data_i;
                OP_SET:    out_d = out_q | wr_data_i;
                OP_CLEAR:  out_d = out_q & ~wr_data_i;
                OP_TOGGLE: out_d = out_q ^ wr_data_i;
                default:   out_d = out_q;
            endcase
        end
    end

    // Pulse counters: load only from idle, otherwise count down to zero.
    // A start request seen while the counter is still running (even at 1)
    // is dropped, so a held request does not retrigger on the final cycle.
    always_comb begin
        for (int unsigned n = 0; n < WIDTH; n++) begin
            cnt_d[n]     = cnt_q[n];
            if (cnt_q[n] == '0) begin
                if (pulse_start_i[n] && (pulse_len_i != '0)) begin
                    cnt_d[n] = pulse_len_i;
                end
            end else begin
                cnt_d[n] = cnt_q[n] - CNT_W'(1);
            end
            busy_d[n]       = (cnt_d[n] != '0);
            pulse_busy_o[n] = (cnt_q[n] != '0);
        end
    end

    // Pads are registered from next-state values so that a write or pulse
    // start shows up on the pads right after the edge that samples it.
    // Open-drain pins never drive high: they pull low by enabling the
    // driver with a 0 and release (OE=0) for a 1.
    always_comb begin
        eff_d     = out_d ^ busy_d;
        pad_out_d = ~gpio_od_i & eff_d;
        pad_oe_d  = gpio_direction_i & (~gpio_od_i | ~eff_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q                <= RST_VAL;
            gpio_output_o        <= '0;
            gpio_output_enable_o <= '0;
            for (int unsigned n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            out_q                <= out_d;
            gpio_output_o        <= pad_out_d;
            gpio_output_enable_o <= pad_oe_d;
            for (int unsigned n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

endmodule

// File: tb/tb_gpio_output_ctrl.sv
// tb_gpio_output_ctrl
//   Directed-vector bench for gpio_output_ctrl with WIDTH=8, CNT_W=4.
module tb_gpio_output_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk_i;
    logic             rst_ni;
    logic             wr_en_i;
    logic [1:0]       wr_op_i;
    logic [WIDTH-1:0] wr_data_i;
    logic [WIDTH-1:0] gpio_direction_i;
    logic [WIDTH-1:0] gpio_od_i;
    logic [WIDTH-1:0] pulse_start_i;
    logic [CNT_W-1:0] pulse_len_i;
    logic [WIDTH-1:0] gpio_output_o;
    logic [WIDTH-1:0] gpio_output_enable_o;
    logic [WIDTH-1:0] pulse_busy_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    gpio_output_ctrl #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .RST_VAL (8'h00)
    ) u_dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .wr_en_i              (wr_en_i),
        .wr_op_i              (wr_op_i),
        .wr_data_i            (wr_data_i),
        .gpio_direction_i     (gpio_direction_i),
        .gpio_od_i            (gpio_od_i),
        .pulse_start_i        (pulse_start_i),
        .pulse_len_i          (pulse_len_i),
        .gpio_output_o        (gpio_output_o),
        .gpio_output_enable_o (gpio_output_enable_o),
        .pulse_busy_o         (pulse_busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the active edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pads(input string tag, input logic [7:0] out_e,
                        input logic [7:0] oe_e, input logic [7:0] busy_e);
        check_eq({tag, ".out"},  32'(gpio_output_o),        32'(out_e));
        check_eq({tag, ".oe"},   32'(gpio_output_enable_o), 32'(oe_e));
        check_eq({tag, ".busy"}, 32'(pulse_busy_o),         32'(busy_e));
    endtask

    task automatic do_write(input logic [1:0] op, input logic [7:0] data);
        wr_en_i   = 1'b1;
        wr_op_i   = op;
        wr_data_i = data;
        tick();
        wr_en_i   = 1'b0;
    endtask

    initial begin
        rst_ni           = 1'b0;
        wr_en_i          = 1'b0;
        wr_op_i          = 2'b00;
        wr_data_i        = '0;
        gpio_direction_i = '0;
        gpio_od_i        = '0;
        pulse_start_i    = '0;
        pulse_len_i      = '0;

        #3;
        pads("reset", 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        pads("post_reset", 8'h00, 8'h00, 8'h00);

        // Register operations, push-pull, all outputs
        gpio_direction_i = 8'hFF;
        do_write(2'b00, 8'hA5);
        pads("write_a5", 8'hA5, 8'hFF, 8'h00);
        do_write(2'b01, 8'h0A);
        pads("set_0a", 8'hAF, 8'hFF, 8'h00);
        do_write(2'b10, 8'h81);
        pads("clear_81", 8'h2E, 8'hFF, 8'h00);
        do_write(2'b11, 8'hFF);
        pads("toggle_ff", 8'hD1, 8'hFF, 8'h00);
        tick();
        pads("hold", 8'hD1, 8'hFF, 8'h00);

        // Basic 3-cycle pulse on bit 0
        do_write(2'b00, 8'h00);
        pads("zero", 8'h00, 8'hFF, 8'h00);
        pulse_len_i   = 4'd3;
        pulse_start_i = 8'h01;
        tick();
        pulse_start_i = 8'h00;
        pads("pulse_c1", 8'h01, 8'hFF, 8'h01);
        tick();
        pads("pulse_c2", 8'h01, 8'hFF, 8'h01);
        tick();
        pads("pulse_c3", 8'h01, 8'hFF, 8'h01);
        tick();
        pads("pulse_end", 8'h00, 8'hFF, 8'h00);

        // Held start does not extend, including at cnt==1
        pulse_start_i = 8'h01;
        tick();
        pads("hold_c1", 8'h01, 8'hFF, 8'h01);
        tick();
        pads("hold_c2", 8'h01, 8'hFF, 8'h01);
        tick();
        pads("hold_c3", 8'h01, 8'hFF, 8'h01);
        tick();
        pulse_start_i = 8'h00;
        pads("hold_end", 8'h00, 8'hFF, 8'h00);
        tick();
        pads("hold_idle", 8'h00, 8'hFF, 8'h00);

        // Zero length: no pulse
        pulse_len_i   = 4'd0;
        pulse_start_i = 8'h01;
        tick();
        pads("len0_a", 8'h00, 8'hFF, 8'h00);
        tick();
        pulse_start_i = 8'h00;
        pads("len0_b", 8'h00, 8'hFF, 8'h00);

        // Open-drain low nibble
        gpio_od_i = 8'h0F;
        do_write(2'b00, 8'h05);
        pads("od", 8'h00, 8'hFA, 8'h00);

        // Input pins still track out_q; OE follows direction after an edge
        gpio_od_i        = 8'h00;
        gpio_direction_i = 8'h00;
        do_write(2'b00, 8'hFF);
        pads("dir_in", 8'hFF, 8'h00, 8'h00);
        gpio_direction_i = 8'hFF;
        #1;
        pads("dir_before_edge", 8'hFF, 8'h00, 8'h00);
        tick();
        pads("dir_out", 8'hFF, 8'hFF, 8'h00);

        // Write during a pulse: inversion continues on the new value
        pulse_len_i   = 4'd2;
        pulse_start_i = 8'h02;
        tick();
        pulse_start_i = 8'h00;
        pads("wp_c1", 8'hFD, 8'hFF, 8'h02);
        do_write(2'b11, 8'h02);
        pads("wp_c2", 8'hFF, 8'hFF, 8'h02);
        tick();
        pads("wp_end", 8'hFD, 8'hFF, 8'h00);

        // Reset in the middle of a long pulse
        do_write(2'b00, 8'h00);
        pulse_len_i   = 4'd10;
        pulse_start_i = 8'h3C;
        tick();
        pulse_start_i = 8'h00;
        pads("rp_c1", 8'h3C, 8'hFF, 8'h3C);
        tick();
        tick();
        tick();
        pads("rp_c4", 8'h3C, 8'hFF, 8'h3C);
        rst_ni = 1'b0;
        #1;
        pads("rp_async", 8'h00, 8'h00, 8'h00);
        tick();
        rst_ni = 1'b1;
        tick();
        pads("rp_rel1", 8'h00, 8'hFF, 8'h00);
        for (int i = 0; i < 10; i++) tick();
        pads("rp_rel2", 8'h00, 8'hFF, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_output_ctrl.md
Name: gpio_output_ctrl

Overview:
- Parametrised next-generation GPIO output stage.
- Holds a WIDTH-bit output data register updated by write/set/clear/toggle operations.
- Adds per-pin open-drain mode and a per-pin timed one-shot pulse (inversion) generator.
- Produces registered pad value and pad output-enable; sits between the GPIO register file and the pad ring.

Parameters:
- WIDTH, 32, number of GPIO pins.
- CNT_W, 16, width of pulse length and per-pin pulse counters.
- RST_VAL, {WIDTH{1'b0}}, reset value of the output data register out_q.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- wr_en_i  in  1  single-cycle strobe applying wr_op_i/wr_data_i.
- wr_op_i  in  2  operation: 00 write, 01 set, 10 clear, 11 toggle.
- wr_data_i  in  WIDTH  value (write) or pin mask (set/clear/toggle).
- gpio_direction_i  in  WIDTH  1 = pin is output.
- gpio_od_i  in  WIDTH  1 = pin is open-drain, 0 = push-pull.
- pulse_start_i  in  WIDTH  per-pin pulse request, level-sampled each cycle.
- pulse_len_i  in  CNT_W  pulse length in cycles, shared by all pins.
- gpio_output_o  out  WIDTH  registered pad output value.
- gpio_output_enable_o  out  WIDTH  registered pad output enable.
- pulse_busy_o  out  WIDTH  1 while the pin's pulse counter is non-zero.

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: out_q = RST_VAL; all counters 0; pulse_busy_o = 0; gpio_output_o = 0; gpio_output_enable_o = 0.
- Write ops, applied at the clock edge when wr_en_i = 1:
  - write: out_q <= wr_data_i.
  - set: out_q <= out_q | wr_data_i.
  - clear: out_q <= out_q & ~wr_data_i.
  - toggle: out_q <= out_q ^ wr_data_i.
  - wr_en_i = 0: out_q holds.
- Pulse start, per pin n: cnt[n] loads pulse_len_i when pulse_start_i[n] = 1, cnt[n] == 0 and pulse_len_i != 0.
- Pulse start is ignored when cnt[n] != 0 (no retrigger, including the cycle where cnt[n] == 1) or when pulse_len_i == 0.
- Otherwise, if cnt[n] != 0, cnt[n] decrements by 1 each cycle. No wrap: decrement stops at 0.
- pulse_busy_o[n] = (cnt[n] != 0), taken directly from the register with no extra latency.
- Effective value: eff[n] = out_q[n] ^ pulse_busy[n]. Pin is inverted for exactly pulse_len_i cycles, then reverts.
- A write to out_q during a pulse takes effect immediately; the inversion continues on the new value.
- Pad outputs are registered and computed from next-state out_q/cnt and current gpio_direction_i/gpio_od_i:
  - gpio_output_o[n] <= gpio_od_i[n] ? 0 : eff_next[n].
  - gpio_output_enable_o[n] <= gpio_direction_i[n] & (gpio_od_i[n] ? ~eff_next[n] : 1).
- Latency: a write or pulse start sampled at edge k is visible on the pads immediately after edge k (1 cycle).
- Direction or OD change: reflected after the next edge.
- Input pins (direction = 0): out_q and pulse counters still operate; gpio_output_enable_o = 0.
- Reset asserted mid-pulse: counters clear immediately and outputs go to reset values. No pulse resumes after reset release.
- Pins are fully independent; simultaneous start/write on many pins is legal.

Test Plan:
- WIDTH=8, CNT_W=4, RST_VAL=8'h00. Reset, then wr_en=1, op=00, data=8'hA5, direction=8'hFF, od=0 -> one cycle later gpio_output_o=8'hA5, gpio_output_enable_o=8'hFF.
- From 8'hA5: set 8'h0A -> 8'hAF; clear 8'h81 -> 8'h2E; toggle 8'hFF -> 8'hD1; each visible 1 cycle after its strobe.
- out_q=8'h00, pulse_start=8'h01, pulse_len=3:
  - bit0 high for exactly 3 cycles, pulse_busy_o[0]=1 for those 3 cycles, then bit0 returns to 0.
  - A second start while busy does not extend the pulse.
  - pulse_len=0 with start=1 -> no pulse.
- od=8'h0F, direction=8'hFF, out_q=8'h05:
  - gpio_output_o=8'h00.
  - gpio_output_enable_o=8'hFA (low nibble OE = ~value, high nibble OE = 1).
- direction=8'h00, write 8'hFF -> gpio_output_o=8'hFF, gpio_output_enable_o=8'h00. Then direction=8'hFF -> OE=8'hFF after the next edge.
- Start a pulse with pulse_len=10, assert rst_ni=0 after 4 cycles -> outputs and pulse_busy_o clear immediately (async). After release, out_q=RST_VAL and no pulse resumes.
